// File: rtl/linear_layer_sched.sv
// Sequencer/arbiter for the shared linear-layer MAC datapath: grants one of two requesters, walks an IN_DIM x OUT_DIM job.
// Define LINEAR_SCHED_PERF_EN to add perf_clr_i / perf_cycles_o (saturating ISSUE+WAIT cycle counter).
module linear_layer_sched #(
  parameter int IN_DIM  = 20,
  parameter int OUT_DIM = 20,
  parameter int ADDR_W  = 5,
  parameter int WADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_i,
  input  logic               abort_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         done_o,
  output logic               busy_o,
  output logic               in_rd_en_o,
  output logic               in_rd_sel_o,
  output logic [ADDR_W-1:0]  in_rd_addr_o,
  output logic [WADDR_W-1:0] w_rd_addr_o,
  output logic               mac_en_o,
  output logic               mac_clr_o,
  output logic               mac_last_o,
  input  logic               mac_acc_valid_i,
  input  logic [31:0]        mac_acc_data_i,
  output logic               out_valid_o,
  output logic [ADDR_W-1:0]  out_addr_o,
  output logic [31:0]        out_data_o,
  output logic               out_sel_o
`ifdef LINEAR_SCHED_PERF_EN
  ,
  input  logic               perf_clr_i,
  output logic [31:0]        perf_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [ADDR_W-1:0]  I_LAST  = ADDR_W'(IN_DIM - 1);
  localparam logic [ADDR_W-1:0]  O_LAST  = ADDR_W'(OUT_DIM - 1);
  localparam logic [WADDR_W-1:0] IN_STEP = WADDR_W'(IN_DIM);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                rr_q, rr_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   o_q, o_d;
  logic [WADDR_W-1:0]  base_q, base_d;
  logic                mac_en_q, mac_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_last_q, mac_last_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_sel_q, out_sel_d;
  logic [1:0]          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    i_d         = i_q;
    o_d         = o_q;
    base_d      = base_q;
    mac_en_d    = (state_q == ISSUE);
    mac_clr_d   = (state_q == ISSUE) && (i_q == '0);
    mac_last_d  = (state_q == ISSUE) && (i_q == I_LAST);
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    done_d      = 2'b00;

    // Abort squashes the job and the in-flight MAC stage but leaves the RR pointer alone.
    if (abort_i) begin
      state_d    = IDLE;
      gnt_d      = 2'b00;
      i_d        = '0;
      o_d        = '0;
      base_d     = '0;
      mac_en_d   = 1'b0;
      mac_clr_d  = 1'b0;
      mac_last_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i != 2'b00) begin
            state_d = ISSUE;
            i_d     = '0;
            o_d     = '0;
            base_d  = '0;
            if (req_i == 2'b11) begin
              gnt_d = rr_q ? 2'b10 : 2'b01;
              rr_d  = ~rr_q;
            end else begin
              gnt_d = req_i;
            end
          end
        end
        ISSUE: begin
          if (i_q == I_LAST) state_d = WAIT;
          else               i_d     = i_q + 1'b1;
        end
        WAIT: begin
          if (mac_acc_valid_i) begin
            out_valid_d = 1'b1;
            out_addr_d  = o_q;
            out_data_d  = mac_acc_data_i;
            out_sel_d   = gnt_q[1];
            if (o_q == O_LAST) begin
              done_d  = gnt_q;
              gnt_d   = 2'b00;
              state_d = IDLE;
              i_d     = '0;
              o_d     = '0;
              base_d  = '0;
            end else begin
              o_d     = o_q + 1'b1;
              base_d  = base_q + IN_STEP;
              i_d     = '0;
              state_d = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      rr_q        <= 1'b0;
      i_q         <= '0;
      o_q         <= '0;
      base_q      <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      done_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      i_q         <= i_d;
      o_q         <= o_d;
      base_q      <= base_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_last_q  <= mac_last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      done_q      <= done_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != IDLE);
  assign in_rd_en_o   = (state_q == ISSUE);
  assign in_rd_sel_o  = gnt_q[1];
  assign in_rd_addr_o = i_q;
  assign w_rd_addr_o  = base_q + WADDR_W'(i_q);
  assign mac_en_o     = mac_en_q;
  assign mac_clr_o    = mac_clr_q;
  assign mac_last_o   = mac_last_q;
  assign out_valid_o  = out_valid_q;
  assign out_addr_o   = out_addr_q;
  assign out_data_o   = out_data_q;
  assign out_sel_o    = out_sel_q;

`ifdef LINEAR_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Clear beats increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 perf_q <= '0;
    else if (perf_clr_i)        perf_q <= '0;
    else if ((state_q != IDLE) && (perf_q != 32'hFFFF_FFFF))
                                perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_linear_layer_sched.sv
// Self-checking bench for linear_layer_sched: datapath model feeds a scoreboard of expected row results.
// Build with LINEAR_SCHED_PERF_EN defined to also exercise the perf counter.
module tb_linear_layer_sched;
  localparam int IN_DIM  = 20;
  localparam int OUT_DIM = 20;
  localparam int ADDR_W  = 5;
  localparam int WADDR_W = 9;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_i;
  logic               abort_i;
  logic [1:0]         gnt_o, done_o;
  logic               busy_o, in_rd_en_o, in_rd_sel_o;
  logic [ADDR_W-1:0]  in_rd_addr_o, out_addr_o;
  logic [WADDR_W-1:0] w_rd_addr_o;
  logic               mac_en_o, mac_clr_o, mac_last_o;
  logic               mac_acc_valid_i;
  logic [31:0]        mac_acc_data_i;
  logic               out_valid_o;
  logic [31:0]        out_data_o;
  logic               out_sel_o;
`ifdef LINEAR_SCHED_PERF_EN
  logic               perf_clr_i;
  logic [31:0]        perf_cycles_o;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              sel;
    logic [1:0]        done;
  } exp_t;

  exp_t        expQ[$];
  exp_t        popE, pushE;
  int          testsRun  = 0;
  int          failCount = 0;
  int          outCount  = 0;
  int          expRow    = 0;
  logic        selExp    = 1'b0;
  logic        d1 = 1'b0, d2 = 1'b0, modelValid = 1'b0, extraValid = 1'b0;
  logic [31:0] modelData = 32'h0;
  bit          timedOut;

  assign mac_acc_valid_i = modelValid | extraValid;
  assign mac_acc_data_i  = modelData;

  linear_layer_sched #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .abort_i(abort_i),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
    .in_rd_en_o(in_rd_en_o), .in_rd_sel_o(in_rd_sel_o), .in_rd_addr_o(in_rd_addr_o),
    .w_rd_addr_o(w_rd_addr_o), .mac_en_o(mac_en_o), .mac_clr_o(mac_clr_o), .mac_last_o(mac_last_o),
    .mac_acc_valid_i(mac_acc_valid_i), .mac_acc_data_i(mac_acc_data_i),
    .out_valid_o(out_valid_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_sel_o(out_sel_o)
`ifdef LINEAR_SCHED_PERF_EN
    , .perf_clr_i(perf_clr_i), .perf_cycles_o(perf_cycles_o)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard pop on out_valid, then datapath model: row result 2 cycles after mac_last.
  always @(negedge clk) begin
    if (out_valid_o) begin
      outCount++;
      testsRun++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL out_unexpected: got out_valid addr=%0d, expected none", out_addr_o);
      end else begin
        popE = expQ.pop_front();
        if ({out_addr_o, out_data_o, out_sel_o, done_o} !== {popE.addr, popE.data, popE.sel, popE.done}) begin
          failCount++;
          $display("[TB] FAIL out_row: got addr=%0d data=%h sel=%b done=%b, expected addr=%0d data=%h sel=%b done=%b",
                   out_addr_o, out_data_o, out_sel_o, done_o, popE.addr, popE.data, popE.sel, popE.done);
        end
      end
    end else if (done_o !== 2'b00) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL done_orphan: got done=%b without out_valid, expected 00", done_o);
    end

    if (!rst_n) begin
      d1 = 1'b0; d2 = 1'b0; modelValid = 1'b0;
    end else begin
      modelValid = d2;
      d2 = d1;
      d1 = mac_last_o;
      if (modelValid) begin
        modelData  = $urandom;
        pushE.addr = ADDR_W'(expRow);
        pushE.data = modelData;
        pushE.sel  = selExp;
        pushE.done = (expRow == OUT_DIM - 1) ? (selExp ? 2'b10 : 2'b01) : 2'b00;
        expQ.push_back(pushE);
        expRow++;
      end
    end
  end

  task automatic runUntilIdle(input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy_o) begin
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic doReset;
    @(negedge clk);
    rst_n = 1'b0; req_i = 2'b00; abort_i = 1'b0; extraValid = 1'b0;
`ifdef LINEAR_SCHED_PERF_EN
    perf_clr_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [62:0] obs;
    @(negedge clk);
    obs = {gnt_o, done_o, busy_o, in_rd_en_o, in_rd_sel_o, in_rd_addr_o, w_rd_addr_o, mac_en_o,
           mac_clr_o, mac_last_o, out_valid_o, out_addr_o, out_data_o, out_sel_o};
    testsRun++;
    if (obs !== 63'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", obs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({gnt_o, busy_o, in_rd_en_o, mac_en_o} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: got gnt=%b busy=%b rd=%b mac=%b, expected all 0", gnt_o, busy_o, in_rd_en_o, mac_en_o);
    end
  endtask

  task automatic test_issue;
    selExp = 1'b0; expRow = 0; outCount = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    testsRun++;
    if ({gnt_o, busy_o} !== 3'b011) begin
      failCount++;
      $display("[TB] FAIL issue_grant: got gnt=%b busy=%b, expected 01 1", gnt_o, busy_o);
    end
    for (int k = 0; k < IN_DIM; k++) begin
      testsRun++;
      if ({in_rd_en_o, in_rd_sel_o, in_rd_addr_o, w_rd_addr_o, mac_en_o, mac_clr_o, mac_last_o} !==
          {1'b1, 1'b0, ADDR_W'(k), WADDR_W'(k), (k > 0), (k == 1), 1'b0}) begin
        failCount++;
        $display("[TB] FAIL issue_step%0d: got en=%b sel=%b addr=%0d w=%0d mac=%b%b%b, expected en=1 sel=0 addr=%0d w=%0d mac=%b%b0",
                 k, in_rd_en_o, in_rd_sel_o, in_rd_addr_o, w_rd_addr_o, mac_en_o, mac_clr_o, mac_last_o, k, k, (k > 0), (k == 1));
      end
      @(negedge clk);
    end
    testsRun++;
    if ({in_rd_en_o, mac_en_o, mac_clr_o, mac_last_o} !== 4'b0101) begin
      failCount++;
      $display("[TB] FAIL issue_last: got en=%b mac=%b clr=%b last=%b, expected 0 1 0 1", in_rd_en_o, mac_en_o, mac_clr_o, mac_last_o);
    end
    runUntilIdle(600, timedOut);
    testsRun++;
    if (timedOut || outCount != OUT_DIM) begin
      failCount++;
      $display("[TB] FAIL issue_job_rows: got %0d rows timeout=%0d, expected %0d rows", outCount, timedOut, OUT_DIM);
    end
  endtask

  task automatic test_full_job;
    int cyc, lastOut, badGap, badSel, lastW;
    selExp = 1'b1; expRow = 0; outCount = 0;
    lastOut = 0; badGap = 0; badSel = 0; lastW = -1; cyc = 0;
    req_i = 2'b10;
    @(negedge clk);
    req_i = 2'b00;
    testsRun++;
    if (gnt_o !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL full_grant: got gnt=%b, expected 10", gnt_o);
    end
    timedOut = 1'b1;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (in_rd_en_o) begin
        lastW = int'(w_rd_addr_o);
        if (in_rd_sel_o !== 1'b1 || gnt_o !== 2'b10) badSel++;
      end
      if (out_valid_o) begin
        if (cyc - lastOut != 23) badGap++;
        lastOut = cyc;
      end
      if (!busy_o) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    #1;
    testsRun++;
    if (timedOut || cyc != IN_DIM * OUT_DIM + 3 * OUT_DIM) begin
      failCount++;
      $display("[TB] FAIL full_cycles: got %0d timeout=%0d, expected 460", cyc, timedOut);
    end
    testsRun++;
    if (lastW != IN_DIM * OUT_DIM - 1) begin
      failCount++;
      $display("[TB] FAIL full_last_waddr: got %0d, expected %0d", lastW, IN_DIM * OUT_DIM - 1);
    end
    testsRun++;
    if (badGap != 0 || badSel != 0) begin
      failCount++;
      $display("[TB] FAIL full_row_timing: got badGap=%0d badSel=%0d, expected 0 0", badGap, badSel);
    end
    testsRun++;
    if (outCount != OUT_DIM) begin
      failCount++;
      $display("[TB] FAIL full_rows: got %0d, expected %0d", outCount, OUT_DIM);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
    doReset();
    req_i = 2'b11;
    for (int j = 0; j < 3; j++) begin
      selExp = seq[j][1]; expRow = 0;
      @(negedge clk);
      if (j == 2) req_i = 2'b00;
      testsRun++;
      if (gnt_o !== seq[j]) begin
        failCount++;
        $display("[TB] FAIL rr_grant%0d: got gnt=%b, expected %b", j, gnt_o, seq[j]);
      end
      runUntilIdle(600, timedOut);
      testsRun++;
      if (timedOut) begin
        failCount++;
        $display("[TB] FAIL rr_job%0d: got timeout, expected job completion", j);
      end
    end
    @(negedge clk);
    testsRun++;
    if (gnt_o !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL rr_idle: got gnt=%b, expected 00", gnt_o);
    end
  endtask

  task automatic test_abort;
    selExp = 1'b0; expRow = 0; outCount = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    timedOut = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (in_rd_en_o && in_rd_addr_o == ADDR_W'(7) && outCount == 3) begin
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    testsRun++;
    if (timedOut || w_rd_addr_o !== WADDR_W'(3 * IN_DIM + 7)) begin
      failCount++;
      $display("[TB] FAIL abort_reach: got w=%0d timeout=%0d, expected w=%0d", w_rd_addr_o, timedOut, 3 * IN_DIM + 7);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    testsRun++;
    if ({gnt_o, in_rd_en_o, mac_en_o, busy_o, out_valid_o, done_o} !== 8'b0) begin
      failCount++;
      $display("[TB] FAIL abort_squash: got gnt=%b rd=%b mac=%b busy=%b ov=%b done=%b, expected all 0",
               gnt_o, in_rd_en_o, mac_en_o, busy_o, out_valid_o, done_o);
    end
    repeat (5) @(negedge clk);
    #1;
    testsRun++;
    if (outCount != 3 || expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL abort_no_output: got rows=%0d pending=%0d, expected 3 0", outCount, expQ.size());
    end
    expRow = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    testsRun++;
    if ({gnt_o, in_rd_en_o, in_rd_addr_o, w_rd_addr_o} !== {2'b01, 1'b1, ADDR_W'(0), WADDR_W'(0)}) begin
      failCount++;
      $display("[TB] FAIL abort_restart: got gnt=%b rd=%b addr=%0d w=%0d, expected 01 1 0 0", gnt_o, in_rd_en_o, in_rd_addr_o, w_rd_addr_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    testsRun++;
    if (busy_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_second: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_stray_valid;
    extraValid = 1'b1;
    @(negedge clk);
    extraValid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL stray_idle: got ov=%b busy=%b, expected 0 0", out_valid_o, busy_o);
    end
    selExp = 1'b0; expRow = 0; outCount = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    repeat (5) @(negedge clk);
    extraValid = 1'b1;
    @(negedge clk);
    extraValid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid_o, in_rd_en_o, in_rd_addr_o} !== {1'b0, 1'b1, ADDR_W'(7)}) begin
      failCount++;
      $display("[TB] FAIL stray_issue: got ov=%b rd=%b addr=%0d, expected 0 1 7", out_valid_o, in_rd_en_o, in_rd_addr_o);
    end
    runUntilIdle(600, timedOut);
    testsRun++;
    if (timedOut || outCount != OUT_DIM) begin
      failCount++;
      $display("[TB] FAIL stray_rows: got %0d rows timeout=%0d, expected %0d", outCount, timedOut, OUT_DIM);
    end
  endtask

  task automatic test_async_reset;
    selExp = 1'b0; expRow = 0; outCount = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({gnt_o, busy_o, in_rd_en_o, mac_en_o, in_rd_addr_o} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got gnt=%b busy=%b rd=%b mac=%b addr=%0d, expected all 0",
               gnt_o, busy_o, in_rd_en_o, mac_en_o, in_rd_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    testsRun++;
    if (outCount != 0 || busy_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_quiet: got rows=%0d busy=%b, expected 0 0", outCount, busy_o);
    end
  endtask

`ifdef LINEAR_SCHED_PERF_EN
  task automatic test_perf;
    doReset();
    selExp = 1'b0; expRow = 0;
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    runUntilIdle(600, timedOut);
    testsRun++;
    if (timedOut || perf_cycles_o !== 32'd460) begin
      failCount++;
      $display("[TB] FAIL perf_job: got %0d timeout=%0d, expected 460", perf_cycles_o, timedOut);
    end
    perf_clr_i = 1'b1;
    @(negedge clk);
    perf_clr_i = 1'b0;
    testsRun++;
    if (perf_cycles_o !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL perf_clr: got %0d, expected 0", perf_cycles_o);
    end
    req_i = 2'b01;
    @(negedge clk);
    req_i = 2'b00;
    repeat (3) @(negedge clk);
    perf_clr_i = 1'b1;
    @(negedge clk);
    perf_clr_i = 1'b0;
    testsRun++;
    if (perf_cycles_o !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL perf_clr_priority: got %0d, expected 0", perf_cycles_o);
    end
    force dut.perf_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.perf_q;
    repeat (2) @(negedge clk);
    testsRun++;
    if (perf_cycles_o !== 32'hFFFF_FFFF) begin
      failCount++;
      $display("[TB] FAIL perf_saturate: got %h, expected ffffffff", perf_cycles_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_i = 2'b00; abort_i = 1'b0;
`ifdef LINEAR_SCHED_PERF_EN
    perf_clr_i = 1'b0;
`endif
    test_reset();
    test_issue();
    test_full_job();
    test_round_robin();
    test_abort();
    test_stray_valid();
    test_async_reset();
`ifdef LINEAR_SCHED_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending rows, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
